simon_seq_ctrl: RTL and testbench

Round sequencer for the Simon Says game: it grows a pseudo-random pattern one step per round, plays it back on the 16 LEDs, then captures and checks the player's button presses against it. It sits between the debounced button/`en` tick front end and the score/seven-segment display logic, and owns all game-flow state. The display block consumes `round`, `win` and `fail` as status.

---
 rtl/simon_pkg.sv | 28 ++
 rtl/simon_lfsr.sv | 31 +++
 rtl/simon_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_simon_seq_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says round sequencer.
// Holds the controller state encoding, the LFSR constants and the LED helper functions.
package simon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADD      = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_FAIL     = 3'd5,
    ST_WIN      = 3'd6
  } ctrl_state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] LED_FAIL     = 16'hFFFF;
  localparam logic [15:0] LED_WIN      = 16'hAAAA;

  function automatic logic [15:0] step_to_led(input logic [3:0] step);
    return 16'h0001 << step;
  endfunction

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 16-bit right-shifting Galois LFSR that generates the pattern steps.
// A load has priority over an advance in the same cycle.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [15:0] load_val,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_r;

  // LFSR state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_r <= SEED_DEFAULT;
    end else if (load) begin
      lfsr_r <= load_val;
    end else if (adv) begin
      lfsr_r <= (lfsr_r >> 1) ^ (lfsr_r[0] ? LFSR_TAPS : 16'h0000);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign lfsr = lfsr_r;

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon Says round sequencer: grows the pattern, plays it back on the LEDs and
// checks the player's presses. All outputs come straight from registers.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 8,
  parameter int ON_TICKS      = 4,
  parameter int OFF_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        en,
  input  logic [15:0] seed,
  input  logic [15:0] in,
  output logic [15:0] led_out,
  output logic [3:0]  round,
  output logic        busy,
  output logic        win,
  output logic        fail
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = $clog2(ON_TICKS + OFF_TICKS + TIMEOUT_TICKS + 1);

  ctrl_state_t state_r, state_s;
  logic [3:0]    round_r, round_s;
  logic [3:0]    index_r, index_s;
  logic [CW-1:0] tick_r, tick_s;
  logic [3:0]    mem_r [MAX_LEN];
  logic [15:0]   led_r, led_s;
  logic          busy_r, win_r, fail_r;
  logic          mem_we_s, lfsr_load_s, lfsr_adv_s;
  logic [15:0]   lfsr_s, load_val_s;
  logic [3:0]    cur_step_s, next_step_s;
  logic [15:0]   expect_led_s;
  logic          lfsr_unused_s;

  assign load_val_s    = (seed == 16'h0000) ? SEED_DEFAULT : seed;
  assign lfsr_unused_s = ^lfsr_s[15:4];

  simon_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load_s),
    .adv      (lfsr_adv_s),
    .load_val (load_val_s),
    .lfsr     (lfsr_s)
  );

  assign cur_step_s   = mem_r[index_r[IW-1:0]];
  assign expect_led_s = step_to_led(cur_step_s);

  // The first step of round 1 is still being written while its LED is loaded
  assign next_step_s = ((state_r == ST_ADD) && (round_r == 4'd0)) ? lfsr_s[3:0]
                                                                  : mem_r[index_s[IW-1:0]];

  // Next-state, counter and index logic
  always_comb begin
    state_s     = state_r;
    round_s     = round_r;
    index_s     = index_r;
    tick_s      = tick_r;
    mem_we_s    = 1'b0;
    lfsr_load_s = 1'b0;
    lfsr_adv_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_FAIL, ST_WIN: begin
        if (start) begin
          state_s     = ST_ADD;
          round_s     = 4'd0;
          index_s     = 4'd0;
          tick_s      = '0;
          lfsr_load_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_ADD: begin
        mem_we_s   = 1'b1;
        lfsr_adv_s = 1'b1;
        round_s    = round_r + 4'd1;
        index_s    = 4'd0;
        tick_s     = '0;
        state_s    = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (en) begin
          if (tick_r == CW'(ON_TICKS - 1)) begin
            state_s = ST_SHOW_OFF;
            tick_s  = '0;
          end else begin
            tick_s = tick_r + CW'(1);
          end
        end else begin
          tick_s = tick_r;
        end
      end
      ST_SHOW_OFF: begin
        if (en) begin
          if (tick_r == CW'(OFF_TICKS - 1)) begin
            tick_s = '0;
            if (index_r == round_r - 4'd1) begin
              state_s = ST_WAIT_IN;
              index_s = 4'd0;
            end else begin
              state_s = ST_SHOW_ON;
              index_s = index_r + 4'd1;
            end
          end else begin
            tick_s = tick_r + CW'(1);
          end
        end else begin
          tick_s = tick_r;
        end
      end
      ST_WAIT_IN: begin
        // A press outranks a simultaneous tick
        if (in != 16'h0000) begin
          if (!is_onehot16(in) || (in != expect_led_s)) begin
            state_s = ST_FAIL;
          end else if (index_r == round_r - 4'd1) begin
            if (round_r == 4'(MAX_LEN)) begin
              state_s = ST_WIN;
            end else begin
              state_s = ST_ADD;
            end
          end else begin
            index_s = index_r + 4'd1;
            tick_s  = '0;
          end
        end else if (en) begin
          if (tick_r == CW'(TIMEOUT_TICKS - 1)) begin
            state_s = ST_FAIL;
          end else begin
            tick_s = tick_r + CW'(1);
          end
        end else begin
          tick_s = tick_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // LED value for the state being entered, so led_out lines up with the state change
  always_comb begin
    led_s = 16'h0000;
    case (state_s)
      ST_SHOW_ON: led_s = step_to_led(next_step_s);
      ST_WAIT_IN: led_s = in;
      ST_ADD:     led_s = (state_r == ST_WAIT_IN) ? in : 16'h0000;
      ST_FAIL:    led_s = LED_FAIL;
      ST_WIN:     led_s = LED_WIN;
      default:    led_s = 16'h0000;
    endcase
  end

  // Controller state and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      round_r <= 4'd0;
      index_r <= 4'd0;
      tick_r  <= '0;
      led_r   <= 16'h0000;
      busy_r  <= 1'b0;
      win_r   <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      round_r <= round_s;
      index_r <= index_s;
      tick_r  <= tick_s;
      led_r   <= led_s;
      busy_r  <= (state_s != ST_IDLE) && (state_s != ST_FAIL) && (state_s != ST_WIN);
      win_r   <= (state_s == ST_WIN);
      fail_r  <= (state_s == ST_FAIL);
    end
  end

  // Pattern memory, one nibble appended per round
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_r[i] <= 4'h0;
      end
    end else if (mem_we_s) begin
      mem_r[round_r[IW-1:0]] <= lfsr_s[3:0];
    end
  end

  assign led_out = led_r;
  assign round   = round_r;
  assign busy    = busy_r;
  assign win     = win_r;
  assign fail    = fail_r;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Directed self-checking bench for simon_seq_ctrl (MAX_LEN=2 so a full game fits).
// Seed 1 yields pattern steps 1 then 0, i.e. LEDs 16'h0002 then 16'h0001.
module tb_simon_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        en;
  logic [15:0] seed;
  logic [15:0] in;
  logic [15:0] led_out;
  logic [3:0]  round;
  logic        busy;
  logic        win;
  logic        fail;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simon_seq_ctrl #(
    .MAX_LEN       (2),
    .ON_TICKS      (4),
    .OFF_TICKS     (2),
    .TIMEOUT_TICKS (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (en),
    .seed    (seed),
    .in      (in),
    .led_out (led_out),
    .round   (round),
    .busy    (busy),
    .win     (win),
    .fail    (fail)
  );

  task automatic cyc(input logic s, input logic e, input logic [15:0] b);
    start = s;
    en    = e;
    in    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    en    = 1'b0;
    in    = 16'h0000;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 16'h0000);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    checks++; if (led_out !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h exp %h", led_out, 16'h0000); end
    checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d exp 0", round); end
    checks++; if ({busy, win, fail} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {busy, win, fail}); end
    rst = 1'b1;
  endtask

  task automatic test_first_round();
    seed = 16'h0001;
    cyc(1'b1, 1'b0, 16'h0000);
    checks++; if ({busy, led_out} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL add_state: got busy=%b led=%h exp busy=1 led=0000", busy, led_out); end
    cyc(1'b0, 1'b0, 16'h0000);
    checks++; if (led_out !== 16'h0002) begin errors++; $display("FAIL first_led: got %h exp %h", led_out, 16'h0002); end
    checks++; if (round !== 4'd1) begin errors++; $display("FAIL first_round: got %0d exp 1", round); end
    cyc(1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    ticks(3);
    checks++; if (led_out !== 16'h0002) begin errors++; $display("FAIL on_hold: got %h exp %h", led_out, 16'h0002); end
    ticks(1);
    checks++; if (led_out !== 16'h0000) begin errors++; $display("FAIL off_led: got %h exp %h", led_out, 16'h0000); end
    ticks(2);
    checks++; if ({busy, led_out, round} !== {1'b1, 16'h0000, 4'd1}) begin errors++; $display("FAIL wait_in_entry: got busy=%b led=%h round=%0d exp 1/0000/1", busy, led_out, round); end
  endtask

  task automatic test_round2();
    cyc(1'b0, 1'b0, 16'h0002);
    checks++; if ({led_out, round} !== {16'h0002, 4'd1}) begin errors++; $display("FAIL press_echo: got led=%h round=%0d exp 0002/1", led_out, round); end
    cyc(1'b0, 1'b0, 16'h0000);
    checks++; if ({led_out, round} !== {16'h0002, 4'd2}) begin errors++; $display("FAIL r2_step0: got led=%h round=%0d exp 0002/2", led_out, round); end
    ticks(4);
    checks++; if (led_out !== 16'h0000) begin errors++; $display("FAIL r2_gap: got %h exp %h", led_out, 16'h0000); end
    ticks(2);
    checks++; if (led_out !== 16'h0001) begin errors++; $display("FAIL r2_step1: got %h exp %h", led_out, 16'h0001); end
    ticks(6);
  endtask

  task automatic test_wrong_press();
    cyc(1'b0, 1'b0, 16'h0004);
    checks++; if ({fail, busy, led_out} !== {1'b1, 1'b0, 16'hFFFF}) begin errors++; $display("FAIL wrong_btn: got fail=%b busy=%b led=%h exp 1/0/ffff", fail, busy, led_out); end
    checks++; if (round !== 4'd2) begin errors++; $display("FAIL fail_round_hold: got %0d exp 2", round); end
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    checks++; if ({round, fail, led_out} !== {4'd1, 1'b0, 16'h0002}) begin errors++; $display("FAIL restart: got round=%0d fail=%b led=%h exp 1/0/0002", round, fail, led_out); end
    ticks(6);
    cyc(1'b0, 1'b0, 16'h0003);
    checks++; if ({fail, led_out} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL two_btn: got fail=%b led=%h exp 1/ffff", fail, led_out); end
  endtask

  task automatic test_timeout();
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    ticks(6);
    ticks(15);
    checks++; if ({fail, busy} !== 2'b01) begin errors++; $display("FAIL timeout_early: got fail=%b busy=%b exp 0/1", fail, busy); end
    ticks(1);
    checks++; if ({fail, led_out} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL timeout: got fail=%b led=%h exp 1/ffff", fail, led_out); end
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    ticks(6);
    ticks(15);
    cyc(1'b0, 1'b1, 16'h0002);
    checks++; if ({fail, busy, led_out} !== {1'b0, 1'b1, 16'h0002}) begin errors++; $display("FAIL press_beats_tick: got fail=%b busy=%b led=%h exp 0/1/0002", fail, busy, led_out); end
    cyc(1'b0, 1'b0, 16'h0000);
    checks++; if (round !== 4'd2) begin errors++; $display("FAIL tick_race_round: got %0d exp 2", round); end
  endtask

  task automatic test_win();
    ticks(12);
    ticks(10);
    cyc(1'b0, 1'b0, 16'h0002);
    checks++; if ({busy, led_out} !== {1'b1, 16'h0002}) begin errors++; $display("FAIL mid_press: got busy=%b led=%h exp 1/0002", busy, led_out); end
    ticks(15);
    checks++; if ({fail, busy} !== 2'b01) begin errors++; $display("FAIL timeout_cleared: got fail=%b busy=%b exp 0/1", fail, busy); end
    cyc(1'b0, 1'b0, 16'h0001);
    checks++; if ({win, busy, led_out, round} !== {1'b1, 1'b0, 16'hAAAA, 4'd2}) begin errors++; $display("FAIL win: got win=%b busy=%b led=%h round=%0d exp 1/0/aaaa/2", win, busy, led_out, round); end
    cyc(1'b0, 1'b1, 16'h0000);
    checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_hold: got %b exp 1", win); end
  endtask

  task automatic test_start_ignored_and_reset();
    seed = 16'h0001;
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    ticks(2);
    cyc(1'b1, 1'b0, 16'h0000);
    checks++; if ({led_out, round, win} !== {16'h0002, 4'd1, 1'b0}) begin errors++; $display("FAIL start_ignored: got led=%h round=%0d win=%b exp 0002/1/0", led_out, round, win); end
    ticks(1);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    checks++; if ({led_out, round, busy} !== {16'h0000, 4'd0, 1'b0}) begin errors++; $display("FAIL mid_reset: got led=%h round=%0d busy=%b exp 0000/0/0", led_out, round, busy); end
    cyc(1'b0, 1'b1, 16'h0000);
    checks++; if ({led_out, busy} !== {16'h0000, 1'b0}) begin errors++; $display("FAIL post_reset_idle: got led=%h busy=%b exp 0000/0", led_out, busy); end
  endtask

  task automatic test_seed_zero();
    seed = 16'h0000;
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0000);
    checks++; if (led_out !== 16'h0002) begin errors++; $display("FAIL seed_default: got %h exp %h", led_out, 16'h0002); end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    en    = 1'b0;
    seed  = 16'h0000;
    in    = 16'h0000;
    test_reset();
    test_first_round();
    test_round2();
    test_wrong_press();
    test_timeout();
    test_win();
    test_start_ignored_and_reset();
    test_seed_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
